// File: rtl/cic_decimator_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cic_pkg                                                         |
// | Brief  : Shared sizing helpers for the parametrised CIC decimator.       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package cic_pkg;

    // A PDM bit maps onto {-1,+1}, which needs two signed bits.
    localparam int CIC_PDM_IN_W = 2;

    function automatic int cic_in_width(input int pdm_mode, input int in_width);
        return (pdm_mode != 0) ? CIC_PDM_IN_W : in_width;
    endfunction

    function automatic int cic_reg_width(input int in_w, input int stages, input int max_rl2);
        return in_w + stages * max_rl2;
    endfunction

    function automatic int cic_rate_clamp(input int rate, input int max_rate);
        if (rate < 1) begin
            return 1;
        end
        if (rate > max_rate) begin
            return max_rate;
        end
        return rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_decimator_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cic_decimator_param_if                                          |
// | Brief  : Control, sample-in and sample-out bundle of the CIC decimator.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface cic_decimator_param_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int RW        = 3
);
    logic                 en;
    logic [RW-1:0]        rate_log2;
    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;

    modport master (
        output en, rate_log2, in_valid, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  en, rate_log2, in_valid, in_data,
        output out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/cic_decimator_param_comb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cic_comb_stage                                                  |
// | Brief  : One comb section: y = x - x_prev, delay loaded on decimation.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module cic_comb_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_dly;

    assign o_data = i_data - r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (i_clr) begin
            r_dly <= '0;
        end else if (i_ld) begin
            r_dly <= i_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cic_decimator_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cic_decimator_param                                             |
// | Brief  : N-stage CIC decimator, run-time R = 2^rate, gain-normalised.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module cic_decimator_param
    import cic_pkg::*;
#(
    parameter int STAGES        = 3,
    parameter int MAX_RATE_LOG2 = 5,
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = 8,
    parameter int PDM_MODE      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cic_decimator_param_if.slave   bus
);
    localparam int c_IN_W = cic_in_width(PDM_MODE, IN_WIDTH);
    localparam int c_W    = cic_reg_width(c_IN_W, STAGES, MAX_RATE_LOG2);
    localparam int c_RW   = $clog2(MAX_RATE_LOG2 + 1);
    localparam int c_SW   = $clog2(c_W + 1);
    localparam int c_CW   = MAX_RATE_LOG2;

    logic [c_W-1:0]       w_x;
    logic [c_W-1:0]       r_int     [STAGES];
    logic [c_W-1:0]       w_int_nxt [STAGES];
    logic [c_W-1:0]       w_comb_out;
    logic [c_SW-1:0]      w_shift;
    logic [OUT_WIDTH-1:0] w_scaled;
    logic [c_CW-1:0]      w_cnt_last;
    logic                 w_accept;
    logic                 w_clr;
    logic [c_RW-1:0]      r_rate_q;
    logic                 r_en_q;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_dec_q;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;

    if (PDM_MODE != 0) begin : g_pdm_in
        logic w_unused_in;
        assign w_unused_in = ^bus.in_data[IN_WIDTH-1:1];
        assign w_x = bus.in_data[0] ? c_W'(1) : {c_W{1'b1}};
    end else begin : g_pcm_in
        assign w_x = {{(c_W-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    end

    assign w_clr    = ~bus.en;
    assign w_accept = bus.en & bus.in_valid;

    // Whole integrator cascade settles within one cycle from the new sample.
    always_comb begin
        logic [c_W-1:0] v_acc;
        v_acc = w_x;
        for (int k = 0; k < STAGES; k++) begin
            v_acc        = r_int[k] + v_acc;
            w_int_nxt[k] = v_acc;
        end
    end

    assign w_cnt_last = ~({c_CW{1'b1}} << r_rate_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_int[k] <= '0;
            end
            r_rate_q    <= c_RW'(1);
            r_en_q      <= 1'b0;
            r_cnt       <= '0;
            r_dec_q     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_en_q <= bus.en;
            if (!bus.en) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_int[k] <= '0;
                end
                r_cnt       <= '0;
                r_dec_q     <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                // Counter is zero on the capture cycle, so the old rate cannot fire here.
                if (!r_en_q) begin
                    r_rate_q <= c_RW'(cic_rate_clamp(int'(bus.rate_log2), MAX_RATE_LOG2));
                end
                r_dec_q <= w_accept && (r_cnt == w_cnt_last);
                if (w_accept) begin
                    for (int k = 0; k < STAGES; k++) begin
                        r_int[k] <= w_int_nxt[k];
                    end
                    r_cnt <= (r_cnt == w_cnt_last) ? '0 : r_cnt + c_CW'(1);
                end
                r_out_valid <= r_dec_q;
                if (r_dec_q) begin
                    r_out_data <= w_scaled;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        logic [c_W-1:0] w_y_in;
        logic [c_W-1:0] w_y_out;
        if (k == 0) begin : g_first
            assign w_y_in = r_int[STAGES-1];
        end else begin : g_next
            assign w_y_in = g_comb[k-1].w_y_out;
        end
        cic_comb_stage #(
            .WIDTH (c_W)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (w_clr),
            .i_ld   (r_dec_q),
            .i_data (w_y_in),
            .o_data (w_y_out)
        );
    end

    assign w_comb_out = g_comb[STAGES-1].w_y_out;

    // Drop exactly the R^N gain bits; wrap in the registers never reaches the kept field.
    assign w_shift  = c_SW'(c_IN_W - OUT_WIDTH) + c_SW'(STAGES) * c_SW'(r_rate_q);
    assign w_scaled = OUT_WIDTH'(w_comb_out >> w_shift);

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_cic_decimator_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_cic_decimator_param                                          |
// | Brief  : PCM and PDM decimators against a boxcar^N FIR reference model.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cic_decimator_param;
    localparam int c_N     = 3;
    localparam int c_MAXRL = 5;
    localparam int c_RW    = 3;

    logic clk;
    logic rst_n;

    cic_decimator_param_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .RW(c_RW)) bus_a ();
    cic_decimator_param_if #(.IN_WIDTH(8), .OUT_WIDTH(5), .RW(c_RW)) bus_b ();

    cic_decimator_param #(
        .STAGES(c_N), .MAX_RATE_LOG2(c_MAXRL), .IN_WIDTH(8), .OUT_WIDTH(8), .PDM_MODE(0)
    ) u_dut_pcm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    cic_decimator_param #(
        .STAGES(c_N), .MAX_RATE_LOG2(c_MAXRL), .IN_WIDTH(8), .OUT_WIDTH(5), .PDM_MODE(1)
    ) u_dut_pdm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int va;
        int vb;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   rate_in;
    int   rq;
    bit   prev_en;
    int   n_acc;
    int   last_a;
    int   last_b;
    int   hist[$];
    int   h[$];
    exp_t q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Impulse response of N cascaded length-R moving sums.
    function automatic void build_h(input int r);
        int tmp[$];
        h = {1};
        repeat (c_N) begin
            tmp = {};
            for (int i = 0; i < h.size() + r - 1; i++) begin
                int s;
                s = 0;
                for (int j = 0; j < r; j++) begin
                    if (i - j >= 0 && i - j < h.size()) s += h[i-j];
                end
                tmp.push_back(s);
            end
            h = tmp;
        end
    endfunction

    function automatic int expect_out(input bit pdm, input int in_w, input int out_w);
        longint acc;
        int     n;
        acc = 0;
        n   = hist.size();
        for (int j = 0; j < h.size() && j < n; j++) begin
            int raw;
            int x;
            raw = hist[n-1-j];
            if (pdm) x = (raw % 2 == 1) ? 1 : -1;
            else     x = (raw >= 128) ? raw - 256 : raw;
            acc += longint'(h[j]) * longint'(x);
        end
        return int'(acc >>> (in_w + c_N * rq - out_w));
    endfunction

    function automatic void model_reset();
        hist.delete();
        q.delete();
        n_acc = 0;
    endfunction

    task automatic step(input bit e, input bit v, input int d);
        bus_a.en       = e;
        bus_b.en       = e;
        bus_a.in_valid = v;
        bus_b.in_valid = v;
        bus_a.in_data  = 8'(d);
        bus_b.in_data  = 8'(d);
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (!e) begin
                model_reset();
            end else begin
                if (!prev_en) begin
                    rq = (rate_in < 1) ? 1 : ((rate_in > c_MAXRL) ? c_MAXRL : rate_in);
                    build_h(1 << rq);
                end
                if (v) begin
                    hist.push_back(d & 255);
                    if (hist.size() > 128) void'(hist.pop_front());
                    n_acc++;
                    if (n_acc % (1 << rq) == 0) begin
                        exp_t ex;
                        ex.due = cyc + 1;
                        ex.va  = expect_out(1'b0, 8, 8);
                        ex.vb  = expect_out(1'b1, 2, 5);
                        q.push_back(ex);
                    end
                end
            end
            prev_en = e;
        end
        #1;
    endtask

    task automatic set_rate(input int r);
        rate_in         = r;
        bus_a.rate_log2 = c_RW'(r);
        bus_b.rate_log2 = c_RW'(r);
        step(1'b0, 1'b0, 0);
        check("hold_a", int'($signed(bus_a.out_data)), last_a);
        check("hold_b", int'($signed(bus_b.out_data)), last_b);
    endtask

    always @(negedge clk) begin
        bit ev;
        ev = 1'b0;
        if (q.size() > 0) begin
            if (q[0].due == cyc) ev = 1'b1;
        end
        check("out_valid_a", int'(bus_a.out_valid), int'(ev));
        check("out_valid_b", int'(bus_b.out_valid), int'(ev));
        if (ev) begin
            check("out_data_a", int'($signed(bus_a.out_data)), q[0].va);
            check("out_data_b", int'($signed(bus_b.out_data)), q[0].vb);
            last_a = q[0].va;
            last_b = q[0].vb;
            void'(q.pop_front());
        end
    end

    initial begin
        rst_n   = 1'b0;
        prev_en = 1'b0;
        rq      = 1;
        last_a  = 0;
        last_b  = 0;
        rate_in = 2;
        model_reset();
        bus_a.en = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.rate_log2 = 3'd2;
        bus_b.en = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.rate_log2 = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ov_a", int'(bus_a.out_valid), 0);
        check("reset_od_a", int'(bus_a.out_data), 0);
        check("reset_ov_b", int'(bus_b.out_valid), 0);
        check("reset_od_b", int'(bus_b.out_data), 0);
        #2 rst_n = 1'b1;

        // R=4, constant +10, sample every cycle
        set_rate(2);
        repeat (48) step(1'b1, 1'b1, 10);
        check("steady_p10", last_a, 10);

        // Asynchronous reset in the middle of a frame
        repeat (6) step(1'b1, 1'b1, 10);
        #2 rst_n = 1'b0;
        #1;
        check("async_ov_a", int'(bus_a.out_valid), 0);
        check("async_od_a", int'(bus_a.out_data), 0);
        check("async_od_b", int'(bus_b.out_data), 0);
        model_reset();
        prev_en = 1'b0;
        last_a  = 0;
        last_b  = 0;
        repeat (2) step(1'b1, 1'b1, 10);
        #2 rst_n = 1'b1;
        repeat (24) step(1'b1, 1'b1, 10);

        // R=32 at full-scale extremes, integrators wrap
        set_rate(5);
        repeat (200) step(1'b1, 1'b1, -128);
        check("steady_m128", last_a, -128);
        repeat (200) step(1'b1, 1'b1, 127);
        check("steady_p127", last_a, 127);

        // Sparse input: one sample every third cycle
        set_rate(2);
        for (int i = 0; i < 120; i++) step(1'b1, (i % 3) == 0, 10);
        check("sparse_p10", last_a, 10);

        // PDM patterns at R=8
        set_rate(3);
        repeat (64) step(1'b1, 1'b1, 1);
        check("pdm_ones", last_b, 8);
        repeat (64) step(1'b1, 1'b1, 0);
        check("pdm_zeros", last_b, -8);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, i % 2);
        check("pdm_alt", last_b, 0);

        // Rate change while enabled is ignored until en toggles; 0 and 7 clamp
        set_rate(2);
        repeat (20) step(1'b1, 1'b1, int'($urandom_range(0, 255)));
        rate_in = 4; bus_a.rate_log2 = 3'd4; bus_b.rate_log2 = 3'd4;
        repeat (20) step(1'b1, 1'b1, int'($urandom_range(0, 255)));
        set_rate(4);
        repeat (40) step(1'b1, 1'b1, int'($urandom_range(0, 255)));
        set_rate(0);
        repeat (20) step(1'b1, 1'b1, int'($urandom_range(0, 255)));
        set_rate(7);
        repeat (80) step(1'b1, 1'b1, int'($urandom_range(0, 255)));

        // Random rates, data and strobe density
        for (int t = 0; t < 8; t++) begin
            set_rate(int'($urandom_range(0, 7)));
            repeat (90) step(1'b1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
        end

        repeat (4) step(1'b1, 1'b0, 0);
        check("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
